uart_regmap: RTL and testbench
==============================

# uart_regmap

Parametrised microcontroller-facing register bank for the UART subsystem. Buffers transmit bytes in a TX FIFO that feeds the UART transmitter through a valid/ready handshake, and buffers received bytes in an RX FIFO. Exposes live and sticky status, occupancy counters and a level interrupt. Sits between the CPU bus and the uart_tx/uart_rx cores.

## Interface
- DATA_WIDTH, 8: register and data width; must be ≥ 8.
- TX_DEPTH, 8: TX FIFO entries; power of two, ≥ 2.
- RX_DEPTH, 8: RX FIFO entries; power of two, ≥ 2.
- ADDR_WIDTH, 3: register address width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  bus write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  bus read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  registered read data.
- tx_data  out  DATA_WIDTH  TX FIFO head (first-word fall-through).
- tx_valid  out  1  TX byte offered to transmitter.
- tx_ready  in  1  transmitter accepts (idle).
- tx_done  in  1  one-cycle pulse: frame finished.
- rx_data  in  DATA_WIDTH  received byte.
- rx_valid  in  1  one-cycle pulse: rx_data valid.
- irq  out  1  registered level interrupt.

## Operation
- Registers (addresses in package):
  - 0 CTRL, RW: bit0 tx_en, bit1 rx_en, bit2 tx_irq_en (TX empty), bit3 rx_irq_en (RX non-empty), bit4 err_irq_en. Upper bits read 0.
  - 1 TXDATA, WO: write pushes wr_data into the TX FIFO. If full: dropped, tx_ovf set. Reads return 0.
  - 2 RXDATA, RO: read returns the RX head and pops. If empty: returns 0, no pop, rx_udf set.
  - 3 STATUS: live bits 0 tx_busy (tx_valid or transmitter not ready), 1 tx_full, 2 tx_empty, 3 rx_empty, 4 rx_full. Sticky bits 5 tx_ovf, 6 rx_ovf, 7 rx_udf. Writing 1 to a sticky bit clears it; writing to live bits has no effect.
  - 4 TXCOUNT, RO: TX occupancy, zero-extended.
  - 5 RXCOUNT, RO: RX occupancy, zero-extended.
  - 6, 7 unmapped: read 0, writes ignored.
- TX path: tx_valid = tx_en & !tx_empty. Pop on tx_valid & tx_ready. Clearing tx_en holds the FIFO contents. tx_data is 0 when the FIFO is empty.
- RX path: on rx_valid & rx_en, push. If full: drop and set rx_ovf. rx_valid with rx_en=0 is ignored silently.
- irq next = (tx_irq_en & tx_empty) | (rx_irq_en & !rx_empty) | (err_irq_en & (tx_ovf | rx_ovf | rx_udf)).
- tx_done is counted only for tx_busy; no sticky flag.

## Timing
- Reset: all FIFOs empty, all counters 0, CTRL 0, sticky bits 0, rd_data 0, tx_valid 0, tx_data 0, irq 0.
- Read latency: rd_data updates on the clock edge after rd_en and holds until the next read. Live status is sampled in the rd_en cycle.
- Write takes effect on the clock edge of wr_en. A TXDATA write is visible on tx_valid/tx_data the following cycle.
- wr_en and rd_en in the same cycle: both are performed independently. A read of CTRL returns the pre-write value.
- Push and pop of the same FIFO in the same cycle:
  - Neither full nor empty: both occur, count unchanged.
  - Full TX FIFO plus a tx pop: the push is accepted.
  - Full RX FIFO plus a RXDATA read: the push is accepted, no overflow.
- Sticky set and W1C clear of the same bit in the same cycle: set wins.
- Pointers wrap modulo depth. Count width is $clog2(DEPTH)+1.
- irq is registered and lags its causes by one cycle.
- Reset asserted mid-frame drops all buffered data immediately (asynchronous).

## Structure
- Package uart_regmap_pkg holds:
  - Address constants CTRL_ADDR..RXCOUNT_ADDR.
  - CTRL bit indices.
  - STATUS bit indices.
- One sub-module, sync_fifo, parametrised by width and depth, instantiated twice:
  - Inputs: push, pop, din.
  - Outputs: dout (FWFT), full, empty, count.
  - Ignores push when full unless popping in the same cycle; ignores pop when empty.

## Test plan
- Reset, then read all six registers -> every value 0 except STATUS = 0x0C (tx_empty, rx_empty).
- CTRL = 0x01, write 0xA5 and 0x3C to TXDATA, hold tx_ready=1 -> tx_data presents 0xA5 then 0x3C on consecutive cycles, TXCOUNT reaches 0, tx_valid drops.
- tx_en=0, write TX_DEPTH+1 bytes -> TXCOUNT = TX_DEPTH, STATUS bits 1 and 5 set. Write STATUS 0x20 -> bit 5 clears, bit 1 remains.
- CTRL = 0x0A, pulse rx_valid with 0x55 -> irq rises two cycles later. Read RXDATA -> rd_data = 0x55, irq falls. Read again -> 0, rx_udf set.
- Fill RX FIFO, then in one cycle rx_valid=1 with 0x77 and a RXDATA read -> no rx_ovf, RXCOUNT stays RX_DEPTH, 0x77 is read last.
- Assert rst mid-transmission with 3 bytes queued -> tx_valid, counts and irq 0 immediately.

Source files
------------

// File: rtl/uart_regmap_pkg.sv
// rtl/uart_regmap_pkg.sv - register addresses, CTRL/STATUS bit indices and sticky flag type
package uart_regmap_pkg;

  localparam int CTRL_ADDR    = 0;
  localparam int TXDATA_ADDR  = 1;
  localparam int RXDATA_ADDR  = 2;
  localparam int STATUS_ADDR  = 3;
  localparam int TXCOUNT_ADDR = 4;
  localparam int RXCOUNT_ADDR = 5;

  localparam int CTRL_WIDTH      = 5;
  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_RX_EN      = 1;
  localparam int CTRL_TX_IRQ_EN  = 2;
  localparam int CTRL_RX_IRQ_EN  = 3;
  localparam int CTRL_ERR_IRQ_EN = 4;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_FULL  = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_OVF   = 6;
  localparam int ST_RX_UDF   = 7;

  typedef struct packed {
    logic rx_udf;
    logic rx_ovf;
    logic tx_ovf;
  } sticky_t;

endpackage

// File: rtl/uart_regmap_sync_fifo.sv
// rtl/uart_regmap_sync_fifo.sv - first-word fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_regmap.sv
// rtl/uart_regmap.sv - CPU register bank with TX/RX FIFOs, status and level interrupt for the UART
module uart_regmap
  import uart_regmap_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  irq
);

  localparam int TXC_W = $clog2(TX_DEPTH) + 1;
  localparam int RXC_W = $clog2(RX_DEPTH) + 1;

  logic [CTRL_WIDTH-1:0] ctrl;
  sticky_t               sticky;

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [TXC_W-1:0]      tx_count;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [RXC_W-1:0]      rx_count;
  logic [DATA_WIDTH-1:0] rx_head;

  logic                  wr_ctrl, wr_status, rd_rxdata;
  logic                  tx_ovf_set, rx_ovf_set, rx_udf_set;
  logic                  tx_busy;
  logic [7:0]            status;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  irq_next;

  assign wr_ctrl   = wr_en & (wr_addr == ADDR_WIDTH'(CTRL_ADDR));
  assign wr_status = wr_en & (wr_addr == ADDR_WIDTH'(STATUS_ADDR));
  assign tx_push   = wr_en & (wr_addr == ADDR_WIDTH'(TXDATA_ADDR));
  assign rd_rxdata = rd_en & (rd_addr == ADDR_WIDTH'(RXDATA_ADDR));

  assign tx_valid = ctrl[CTRL_TX_EN] & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & ctrl[CTRL_RX_EN];
  assign rx_pop   = rd_rxdata & ~rx_empty;

  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
  assign rx_udf_set = rd_rxdata & rx_empty;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wr_data),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // The transmitter counts as idle on the cycle its frame-complete pulse arrives
  assign tx_busy = tx_valid | (~tx_ready & ~tx_done);

  always_comb begin
    status              = '0;
    status[ST_TX_BUSY]  = tx_busy;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_OVF]   = sticky.tx_ovf;
    status[ST_RX_OVF]   = sticky.rx_ovf;
    status[ST_RX_UDF]   = sticky.rx_udf;
  end

  always_comb begin
    rd_next = '0;
    case (rd_addr)
      ADDR_WIDTH'(CTRL_ADDR):    rd_next = DATA_WIDTH'(ctrl);
      ADDR_WIDTH'(RXDATA_ADDR):  rd_next = rx_head;
      ADDR_WIDTH'(STATUS_ADDR):  rd_next = DATA_WIDTH'(status);
      ADDR_WIDTH'(TXCOUNT_ADDR): rd_next = DATA_WIDTH'(tx_count);
      ADDR_WIDTH'(RXCOUNT_ADDR): rd_next = DATA_WIDTH'(rx_count);
      default:                   rd_next = '0;
    endcase
  end

  assign irq_next = (ctrl[CTRL_TX_IRQ_EN] & tx_empty)
                  | (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty)
                  | (ctrl[CTRL_ERR_IRQ_EN] & (sticky.tx_ovf | sticky.rx_ovf | sticky.rx_udf));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      sticky  <= '0;
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= wr_data[CTRL_WIDTH-1:0];
      // A new error event in the clearing cycle keeps its flag set
      sticky.tx_ovf <= tx_ovf_set | (sticky.tx_ovf & ~(wr_status & wr_data[ST_TX_OVF]));
      sticky.rx_ovf <= rx_ovf_set | (sticky.rx_ovf & ~(wr_status & wr_data[ST_RX_OVF]));
      sticky.rx_udf <= rx_udf_set | (sticky.rx_udf & ~(wr_status & wr_data[ST_RX_UDF]));
      if (rd_en) rd_data <= rd_next;
      irq <= irq_next;
    end
  end

endmodule

// File: tb/tb_uart_regmap.sv
// tb/tb_uart_regmap.sv - scoreboard bench for uart_regmap: bus reads and TX handshakes checked by monitor
module tb_uart_regmap;

  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic [AW-1:0] A_CTRL    = 3'd0;
  localparam logic [AW-1:0] A_TXDATA  = 3'd1;
  localparam logic [AW-1:0] A_RXDATA  = 3'd2;
  localparam logic [AW-1:0] A_STATUS  = 3'd3;
  localparam logic [AW-1:0] A_TXCOUNT = 3'd4;
  localparam logic [AW-1:0] A_RXCOUNT = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          tx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] rd_exp_q[$];
  string         rd_name_q[$];
  logic [DW-1:0] tx_exp_q[$];
  logic          rd_seen;

  uart_regmap #(.DATA_WIDTH(DW), .TX_DEPTH(8), .RX_DEPTH(8), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) rd_seen <= 1'b0;
    else      rd_seen <= rd_en;
  end

  // Monitor: compares every completed read and every TX handshake against the queues
  always @(negedge clk) begin
    if (rst && rd_seen) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", rd_data);
      end else begin
        check(rd_name_q.pop_front(), 32'(rd_data), 32'(rd_exp_q.pop_front()));
      end
    end
    if (rst && tx_valid && tx_ready) begin
      if (tx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no handshake", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(tx_exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic rx_pulse(input logic [DW-1:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    idle(3);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_irq",      32'(irq),      32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    rst = 1'b1;
    idle(1);
    bus_read(A_CTRL,    8'h00, "rst_ctrl");
    bus_read(A_TXDATA,  8'h00, "rst_txdata");
    bus_read(A_STATUS,  8'h0C, "rst_status");
    bus_read(A_TXCOUNT, 8'h00, "rst_txcount");
    bus_read(A_RXCOUNT, 8'h00, "rst_rxcount");
    bus_read(3'd6,      8'h00, "unmapped_6");
    bus_read(3'd7,      8'h00, "unmapped_7");
    bus_read(A_RXDATA,  8'h00, "rst_rxdata_empty");
    bus_read(A_STATUS,  8'h8C, "udf_after_empty_read");
    bus_write(A_STATUS, 8'h80);
    bus_read(A_STATUS,  8'h0C, "udf_cleared");

    // Two bytes through the TX handshake
    bus_write(A_CTRL, 8'h01);
    tx_exp_q.push_back(8'hA5);
    tx_exp_q.push_back(8'h3C);
    bus_write(A_TXDATA, 8'hA5);
    bus_write(A_TXDATA, 8'h3C);
    idle(3);
    check("tx_valid_drained", 32'(tx_valid), 32'd0);
    bus_read(A_TXCOUNT, 8'h00, "txcount_drained");
    bus_read(A_STATUS,  8'h0C, "status_tx_idle");

    // TX overflow with transmitter disabled, then W1C of tx_ovf
    bus_write(A_CTRL, 8'h00);
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 8'(8'h10 + i));
    bus_read(A_TXCOUNT, 8'h08, "txcount_full");
    bus_read(A_STATUS,  8'h2A, "status_tx_ovf");
    bus_write(A_STATUS, 8'h20);
    bus_read(A_STATUS,  8'h0A, "status_ovf_cleared");
    for (int i = 0; i < 8; i++) tx_exp_q.push_back(8'(8'h10 + i));
    bus_write(A_CTRL, 8'h01);
    idle(10);
    bus_read(A_TXCOUNT, 8'h00, "txcount_after_drain");

    // RX interrupt timing and underflow
    bus_write(A_CTRL, 8'h0A);
    rx_pulse(8'h55);
    check("irq_not_yet", 32'(irq), 32'd0);
    idle(1);
    check("irq_rise", 32'(irq), 32'd1);
    bus_read(A_RXDATA, 8'h55, "rxdata_55");
    check("irq_still_high", 32'(irq), 32'd1);
    idle(1);
    check("irq_fall", 32'(irq), 32'd0);
    bus_read(A_RXDATA, 8'h00, "rxdata_udf");
    bus_read(A_STATUS, 8'h8C, "status_rx_udf");
    bus_write(A_STATUS, 8'h80);

    // Full RX FIFO with simultaneous push and read
    for (int i = 0; i < 8; i++) rx_pulse(8'(8'h60 + i));
    bus_read(A_RXCOUNT, 8'h08, "rxcount_full");
    rd_exp_q.push_back(8'h60);
    rd_name_q.push_back("rx_full_push_pop");
    rx_valid = 1'b1; rx_data = 8'h77; rd_en = 1'b1; rd_addr = A_RXDATA;
    @(posedge clk); #1;
    rx_valid = 1'b0; rd_en = 1'b0;
    bus_read(A_STATUS,  8'h14, "status_rx_full_no_ovf");
    bus_read(A_RXCOUNT, 8'h08, "rxcount_still_full");
    for (int i = 1; i < 8; i++) bus_read(A_RXDATA, 8'(8'h60 + i), "rx_fifo_order");
    bus_read(A_RXDATA,  8'h77, "rx_last_77");
    bus_read(A_RXCOUNT, 8'h00, "rxcount_empty");
    bus_write(A_CTRL, 8'h00);
    rx_pulse(8'hEE);
    bus_read(A_RXCOUNT, 8'h00, "rx_disabled_ignored");
    bus_read(A_STATUS,  8'h0C, "status_rx_disabled");

    // Asynchronous reset with TX bytes queued and irq asserted
    tx_ready = 1'b0;
    bus_write(A_CTRL, 8'h0B);
    bus_write(A_TXDATA, 8'h01);
    bus_write(A_TXDATA, 8'h02);
    bus_write(A_TXDATA, 8'h03);
    rx_pulse(8'h99);
    idle(1);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    check("pre_rst_tx_data",  32'(tx_data),  32'h01);
    check("pre_rst_irq",      32'(irq),      32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid),     32'd0);
    check("async_rst_tx_data",  32'(tx_data),      32'd0);
    check("async_rst_irq",      32'(irq),          32'd0);
    check("async_rst_txcount",  32'(dut.tx_count), 32'd0);
    check("async_rst_rxcount",  32'(dut.rx_count), 32'd0);
    idle(2);
    tx_ready = 1'b1;
    rst = 1'b1;
    idle(1);
    bus_read(A_TXCOUNT, 8'h00, "post_rst_txcount");
    bus_read(A_RXCOUNT, 8'h00, "post_rst_rxcount");
    bus_read(A_STATUS,  8'h0C, "post_rst_status");
    bus_read(A_CTRL,    8'h00, "post_rst_ctrl");

    idle(2);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
